// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
//
// Shared definitions for the multiplier scheduler slice.
//   MUL_MAX_REQ  - largest requester count the scheduler supports; it sets
//                  the width of the requester index carried in a tag.
//   MUL_IDX_W    - bit width of a requester index.
//   mul_tag_t    - per-operation tag (valid bit + requester index) that
//                  travels alongside the multiplier pipeline.
//   mul_latency  - acceptance-to-response latency in clock edges for a
//                  multiplier of pipeline depth p.
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_MAX_REQ = 8;
    localparam int MUL_IDX_W   = $clog2(MUL_MAX_REQ);

    typedef struct packed {
        logic                 valid;
        logic [MUL_IDX_W-1:0] index;
    } mul_tag_t;

    // The multiplier registers its operands once and then adds p further
    // stages, so a result leaves it p+1 edges after acceptance.
    function automatic int mul_latency(input int p);
        return p + 1;
    endfunction

endpackage

// File: rtl/mult.sv
// ---------------------------------------------------------------------------
// mult
//
// Pipelined signed n x n multiplier returning the low n product bits.
// The product of the operands presented in one cycle is captured at the
// next rising edge and then moves through p more stages, so it appears on
// y p+1 edges later. All stage registers clear on reset.
//
// Parameters:
//   n  - operand / result width
//   p  - number of pipeline stages after the operand capture (0..3)
// Ports:
//   Clock   in   rising-edge clock
//   nReset  in   asynchronous active-low reset
//   a, b    in   signed operands
//   y       out  low n bits of a*b, delayed p+1 edges
// ---------------------------------------------------------------------------
module mult #(
    parameter int n = 8,
    parameter int p = 1
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic signed [n-1:0] a,
    input  logic signed [n-1:0] b,
    output logic        [n-1:0] y
);

    // The low n bits of a two's-complement product do not depend on
    // whether the operands are read as signed or unsigned, so an n-bit
    // truncating multiply gives the wrapped signed result directly.
    logic [n-1:0] prod_lo;
    logic [n-1:0] stage [p+1];

    assign prod_lo = a * b;

    // Product pipeline: stage 0 holds the freshly computed product, each
    // later stage simply delays it one more edge.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i <= p; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= prod_lo;
            for (int i = 1; i <= p; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign y = stage[p];

endmodule

// File: rtl/rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
//
// Combinational single-grant arbiter for the multiplier scheduler.
//
// Configuration macro: MUL_SCHED_RR_EN
//   defined   - round-robin: the search starts at a pointer register, and
//               after a grant to g the pointer moves to (g+1) mod R. With
//               no grant the pointer holds. Clock/nReset ports exist only
//               in this build.
//   undefined - fixed priority, lowest index wins; no state at all.
//
// Parameters:
//   R  - number of requesters (2..MUL_MAX_REQ)
// Ports:
//   Clock      in   rising-edge clock            (round-robin build only)
//   nReset     in   async active-low reset        (round-robin build only)
//   valid      in   request strobes
//   grant      out  one-hot grant, zero when no request is valid
//   grant_idx  out  index of the granted requester (0 when none)
//   any_grant  out  a grant is being issued this cycle
// ---------------------------------------------------------------------------
module rr_arb
    import mul_pkg::*;
#(
    parameter int R = 4
) (
`ifdef MUL_SCHED_RR_EN
    input  logic                 Clock,
    input  logic                 nReset,
`endif
    input  logic [R-1:0]         valid,
    output logic [R-1:0]         grant,
    output logic [MUL_IDX_W-1:0] grant_idx,
    output logic                 any_grant
);

`ifdef MUL_SCHED_RR_EN

    logic [MUL_IDX_W-1:0] ptr;
    logic [MUL_IDX_W-1:0] ptr_next;

    // Rotating search done as two ordered passes instead of a modulo
    // index: the first pass looks at indices at or above the pointer,
    // the second wraps round to the ones below it. The first valid
    // requester met wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < R; i++) begin
                if (!any_grant && valid[i] &&
                    ((pass == 0) == (MUL_IDX_W'(i) >= ptr))) begin
                    any_grant = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = MUL_IDX_W'(i);
                end
            end
        end
    end

    // Pointer advances to the requester after the one just served.
    always_comb begin
        ptr_next = ptr;
        if (any_grant) begin
            if (grant_idx == MUL_IDX_W'(R - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + 1'b1;
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

`else

    // Fixed priority: scan upward, the lowest valid index wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int i = 0; i < R; i++) begin
            if (!any_grant && valid[i]) begin
                any_grant = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = MUL_IDX_W'(i);
            end
        end
    end

`endif

endmodule

// File: rtl/mul_sched.sv
// ---------------------------------------------------------------------------
// mul_sched
//
// Shares one pipelined signed N x N multiplier among R requesters. At most
// one request is accepted per cycle (ReqValid[i] & ReqReady[i] at a rising
// edge). The granted operands go into the multiplier in the grant cycle,
// and a tag (valid + requester index) travels alongside the operation
// through a pipeline of depth P+1. An output register then captures the
// product and tag, so a request accepted at edge t answers with a one-hot
// RspValid and RspOut during the cycle after edge t+P+1. Responses have no
// backpressure.
//
// Configuration macro: MUL_SCHED_RR_EN
//   defined   - round-robin arbitration
//   undefined - fixed priority, lowest index first
//
// Parameters:
//   N  - operand / result width
//   R  - number of requesters (2..8)
//   P  - multiplier pipeline depth (0..3)
// Ports:
//   Clock     in   rising-edge clock
//   nReset    in   asynchronous active-low reset
//   ReqValid  in   [R]     request strobes
//   ReqA      in   [R][N]  signed operand A per requester
//   ReqB      in   [R][N]  signed operand B per requester
//   ReqReady  out  [R]     one-hot grant (combinational)
//   RspValid  out  [R]     one-hot response strobe, one cycle wide
//   RspOut    out  [N]     wrapped signed product, zero when no response
//   Busy      out          some accepted request has not yet responded
// ---------------------------------------------------------------------------
module mul_sched
    import mul_pkg::*;
#(
    parameter int N = 8,
    parameter int R = 4,
    parameter int P = 1
) (
    input  logic                Clock,
    input  logic                nReset,
    input  logic [R-1:0]        ReqValid,
    input  logic [R-1:0][N-1:0] ReqA,
    input  logic [R-1:0][N-1:0] ReqB,
    output logic [R-1:0]        ReqReady,
    output logic [R-1:0]        RspValid,
    output logic [N-1:0]        RspOut,
    output logic                Busy
);

    localparam int TAG_DEPTH = mul_latency(P);

    logic [R-1:0]         grant;
    logic [MUL_IDX_W-1:0] grant_idx;
    logic                 any_grant;
    logic [N-1:0]         op_a;
    logic [N-1:0]         op_b;
    logic [N-1:0]         mul_y;
    mul_tag_t             tag_pipe [TAG_DEPTH];
    mul_tag_t             rsp_tag;
    logic [N-1:0]         rsp_prod;

    rr_arb #(
        .R(R)
    ) u_arb (
`ifdef MUL_SCHED_RR_EN
        .Clock     (Clock),
        .nReset    (nReset),
`endif
        .valid     (ReqValid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign ReqReady = grant;

    // Operand mux driven by the one-hot grant. With no grant the operands
    // sit at zero so the multiplier input does not toggle needlessly.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < R; i++) begin
            if (grant[i]) begin
                op_a = ReqA[i];
                op_b = ReqB[i];
            end
        end
    end

    mult #(
        .n(N),
        .p(P)
    ) u_mult (
        .Clock  (Clock),
        .nReset (nReset),
        .a      (op_a),
        .b      (op_b),
        .y      (mul_y)
    );

    // Tag pipeline, one entry per multiplier register so the last entry
    // lines up with the product presented on mul_y. An idle cycle pushes
    // an invalid tag, which is what leaves gaps in the response stream.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= {any_grant, grant_idx};
            for (int i = 1; i < TAG_DEPTH; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Output register. The product is captured only alongside a valid tag,
    // so RspOut reads zero in every cycle without a response.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rsp_tag  <= '0;
            rsp_prod <= '0;
        end else begin
            rsp_tag  <= tag_pipe[TAG_DEPTH-1];
            rsp_prod <= tag_pipe[TAG_DEPTH-1].valid ? mul_y : '0;
        end
    end

    // Decode the response index into the one-hot strobe.
    always_comb begin
        RspValid = '0;
        for (int i = 0; i < R; i++) begin
            if (rsp_tag.valid && (rsp_tag.index == MUL_IDX_W'(i))) begin
                RspValid[i] = 1'b1;
            end
        end
    end

    assign RspOut = rsp_prod;

    // Busy covers every operation between acceptance and the end of its
    // response cycle.
    always_comb begin
        Busy = rsp_tag.valid;
        for (int i = 0; i < TAG_DEPTH; i++) begin
            Busy = Busy | tag_pipe[i].valid;
        end
    end

endmodule
